mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one mem_control instance between instruction fetch (m0, read-only) and the load/store unit (m1, read/write).
- Round-robin arbitration; one outstanding access at a time.
- Holds all request fields stable for the full read and write sequences that mem_control requires.
- Provides the alignment and range checks mem_control lacks, and never issues a read while a write sequence is in progress.

Parameters:
ADDR_LO, 32'h0000_0000, lowest legal byte address (inclusive).
ADDR_HI, 32'h0000_07FF, highest legal byte address (inclusive); the default matches 512 rows x 4 B.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
m0_req_i  in  1  fetch request; held until m0_gnt_o
m0_addr_i  in  32  byte address
m0_acc_i  in  2  access size, MEM_ACCESS_*
m0_sext_i  in  1  sign-extend the read result
m0_gnt_o  out  1  request accepted this cycle
m0_rvalid_o  out  1  read data/err valid, 1-cycle pulse
m0_rdata_o  out  32  read data
m0_err_o  out  1  misaligned or out of range; qualified by m0_rvalid_o
m1_req_i  in  1  data request; held until m1_gnt_o
m1_we_i  in  1  1 = write
m1_addr_i  in  32  byte address
m1_acc_i  in  2  access size
m1_sext_i  in  1  sign-extend the read result
m1_wdata_i  in  32  write data, right-aligned
m1_gnt_o  out  1  request accepted
m1_rvalid_o  out  1  read completion pulse
m1_rdata_o  out  32  read data
m1_wdone_o  out  1  write completion pulse
m1_err_o  out  1  error; qualified by m1_rvalid_o or m1_wdone_o
mem_r_en_o, mem_sext_o, mem_acc_r_o[2], mem_addr_r_o[32]  out  read port toward mem_control
mem_data_r_i  in  32  read data from mem_control
mem_wr_en_o, mem_acc_w_o[2], mem_addr_w_o[32], mem_data_w_o[32]  out  write port toward mem_control
mem_wr_ready_i  in  1  mem_control ready

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; last_gnt=m0.
  - All outputs and latched request registers are 0.
  - An in-flight access is abandoned with no completion pulse.
- States:
  - IDLE: accepts a request only when mem_wr_ready_i=1. This covers mem_control's own reset cycle.
  - RD_ADDR: read issue cycle.
  - RD_DATA: read data cycle.
  - WR_READ: first write cycle (mem_control reads the old word).
  - WR_STORE: second write cycle (mem_control stores the merged word).
  - ERR: error response cycle.
- Arbitration in IDLE:
  - If exactly one master requests, it wins.
  - If both request, the master other than last_gnt wins; the first contention after reset goes to m1.
  - The winner's gnt_o pulses for 1 cycle, combinationally in IDLE.
  - Request fields are latched into the request register; last_gnt is updated.
  - Next state is ERR if the request is illegal; otherwise RD_ADDR for a read, WR_READ for a write.
  - m0_we is implicitly 0.
- Illegal request:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr<ADDR_LO, or addr+size-1>ADDR_HI; compute with a 33-bit sum, no wrap.
- ERR:
  - Pulses rvalid (read) or wdone (write) together with err=1; rdata=0.
  - No mem_* enable is asserted. Returns to IDLE.
- Read, granted at cycle N:
  - Cycles N+1 and N+2: mem_r_en_o=1; addr, acc and sext are driven from the latch and held identical in both cycles.
  - Cycle N+2: rvalid_o=1, rdata_o=mem_data_r_i. Return to IDLE.
- Write, granted at cycle N:
  - N+1 (WR_READ): mem_wr_en_o=1 with addr, acc and data from the latch. If mem_wr_ready_i=0, stay in WR_READ.
  - Next cycle (WR_STORE): hold the same fields and keep mem_wr_en_o=1; mem_r_en_o=0.
  - wdone_o=1 is pulsed in WR_STORE. Return to IDLE.
- Throughput and latency:
  - Minimum spacing is one access every 3 cycles; no accept occurs in RD_DATA or WR_STORE.
  - Read latency is gnt+2; write completes at gnt+2.
- Output behaviour outside active states:
  - mem_* address and data are 0 in IDLE.
  - rdata_o is held at 0 except in the valid cycle.
- Masters:
  - A master that deasserts req before gnt simply loses the slot.
  - The responses to m0 and m1 never pulse in the same cycle.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, RD_ADDR, RD_DATA, WR_READ, WR_STORE, ERR).
  - Master id type.
  - Request struct (addr, acc, sext, we, wdata, id).
- Access size encodings come from the existing MEM_ACCESS_* constants.
- One sub-module, mem_rr_pick2: 2-way round-robin picker (req[1:0], last → grant[1:0]).

Test Plan:
1. Reset, then m0 reads a word at 0x10 holding 0xDEADBEEF → m0_gnt at N, mem_addr_r_o=0x10 held at N+1 and N+2, m0_rvalid with rdata 0xDEADBEEF at N+2.
2. m1 writes a byte 0xA5 to 0x13 → mem_wr_en_o high for 2 cycles with identical fields, m1_wdone at N+2; a follow-up word read returns 0xA5ADBEEF.
3. m0 and m1 request continuously → grants alternate m1,m0,m1,m0, every 3 cycles; m1 wins first.
4. m1 reads a halfword at 0x11 with sext → m1_err=1 with m1_rvalid at N+1, rdata=0, mem_r_en_o never asserted.
5. m0 reads a word at 0x800 → err; a word read at 0x7FC succeeds.
6. rst_i asserted in WR_STORE → next cycle all outputs are 0, no wdone; the first request after reset is granted only once mem_wr_ready_i=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_control arbiter.
// Provides the access-size encodings, the arbiter state enum, the master id type,
// the latched request record, and the legality check for a request.
package mem_arb_pkg;

  localparam logic [1:0] MEM_ACCESS_BYTE = 2'd0;
  localparam logic [1:0] MEM_ACCESS_HALF = 2'd1;
  localparam logic [1:0] MEM_ACCESS_WORD = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrRead,
    StWrStore,
    StErr
  } arb_state_e;

  typedef enum logic {
    MstM0 = 1'b0,
    MstM1 = 1'b1
  } mst_id_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  acc;
    logic        sext;
    logic        we;
    logic [31:0] wdata;
    mst_id_e     id;
  } arb_req_t;

  // Number of bytes touched by an access; 0 marks an unknown encoding.
  function automatic logic [2:0] acc_bytes(input logic [1:0] acc);
    case (acc)
      MEM_ACCESS_BYTE: return 3'd1;
      MEM_ACCESS_HALF: return 3'd2;
      MEM_ACCESS_WORD: return 3'd4;
      default:         return 3'd0;
    endcase
  endfunction

  // Misaligned, unknown size or outside [lo, hi]. The end address uses 33 bits so a
  // request near the top of the address space cannot wrap back into range.
  function automatic logic req_illegal(input logic [31:0] addr, input logic [1:0] acc,
                                       input logic [31:0] lo, input logic [31:0] hi);
    logic [2:0]  size;
    logic [32:0] last;
    size = acc_bytes(acc);
    last = {1'b0, addr} + {30'b0, size} - 33'd1;
    if (size == 3'd0) return 1'b1;
    if (acc == MEM_ACCESS_HALF && addr[0]) return 1'b1;
    if (acc == MEM_ACCESS_WORD && addr[1:0] != 2'b00) return 1'b1;
    if (addr < lo) return 1'b1;
    if (last > {1'b0, hi}) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_rr_pick2.sv
// Two-way round-robin picker.
//   req_i  : request vector, bit 0 = m0, bit 1 = m1
//   last_i : 1 when m1 held the most recent grant
//   gnt_o  : one-hot (or zero) grant
module mem_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one mem_control instance between instruction fetch (m0, read-only) and the
// load/store unit (m1). One access outstanding at a time, round-robin on contention.
// Rejects misaligned / out-of-range requests with an error response and holds all
// request fields stable for mem_control's two-cycle read and write sequences.
//   m0_*  : fetch request/grant and read response
//   m1_*  : data request/grant, read response and write completion
//   mem_* : read and write ports toward mem_control, mem_wr_ready_i its ready
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_07FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [1:0]  m0_acc_i,
  input  logic        m0_sext_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [1:0]  m1_acc_i,
  input  logic        m1_sext_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_wdone_o,
  output logic        m1_err_o,
  output logic        mem_r_en_o,
  output logic        mem_sext_o,
  output logic [1:0]  mem_acc_r_o,
  output logic [31:0] mem_addr_r_o,
  input  logic [31:0] mem_data_r_i,
  output logic        mem_wr_en_o,
  output logic [1:0]  mem_acc_w_o,
  output logic [31:0] mem_addr_w_o,
  output logic [31:0] mem_data_w_o,
  input  logic        mem_wr_ready_i
);

  arb_state_e state_q;
  mst_id_e    last_gnt_q;
  arb_req_t   req_q;
  arb_req_t   new_req;
  logic [1:0] pick;
  logic       accept;
  logic       new_illegal;

  mem_rr_pick2 u_pick (
    .req_i  ({m1_req_i, m0_req_i}),
    .last_i (last_gnt_q == MstM1),
    .gnt_o  (pick)
  );

  // mem_wr_ready_i low also covers mem_control's own reset cycle.
  assign accept   = !rst_i && (state_q == StIdle) && mem_wr_ready_i && (pick != 2'b00);
  assign m0_gnt_o = accept && pick[0];
  assign m1_gnt_o = accept && pick[1];

  always_comb begin
    new_req = '0;
    if (pick[1]) begin
      new_req.addr  = m1_addr_i;
      new_req.acc   = m1_acc_i;
      new_req.sext  = m1_sext_i;
      new_req.we    = m1_we_i;
      new_req.wdata = m1_wdata_i;
      new_req.id    = MstM1;
    end else begin
      new_req.addr  = m0_addr_i;
      new_req.acc   = m0_acc_i;
      new_req.sext  = m0_sext_i;
      new_req.id    = MstM0;
    end
  end

  assign new_illegal = req_illegal(new_req.addr, new_req.acc, ADDR_LO, ADDR_HI);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      last_gnt_q <= MstM0;
      req_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            req_q      <= new_req;
            last_gnt_q <= new_req.id;
            if (new_illegal)     state_q <= StErr;
            else if (new_req.we) state_q <= StWrRead;
            else                 state_q <= StRdAddr;
          end
        end
        StRdAddr:  state_q <= StRdData;
        StRdData:  state_q <= StIdle;
        StWrRead:  if (mem_wr_ready_i) state_q <= StWrStore;
        StWrStore: state_q <= StIdle;
        StErr:     state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Everything below is gated by reset so an access caught mid-flight by rst_i neither
  // completes in mem_control nor pulses a response.
  logic        rd_act, wr_act, err_act;
  logic        rvalid_any, wdone_any;
  logic [31:0] rdata_any;

  assign rd_act     = !rst_i && (state_q == StRdAddr || state_q == StRdData);
  assign wr_act     = !rst_i && (state_q == StWrRead || state_q == StWrStore);
  assign err_act    = !rst_i && (state_q == StErr);
  assign rvalid_any = (!rst_i && state_q == StRdData) || (err_act && !req_q.we);
  assign wdone_any  = (!rst_i && state_q == StWrStore) || (err_act && req_q.we);
  assign rdata_any  = (!rst_i && state_q == StRdData) ? mem_data_r_i : 32'h0;

  assign mem_r_en_o   = rd_act;
  assign mem_sext_o   = rd_act && req_q.sext;
  assign mem_acc_r_o  = rd_act ? req_q.acc : 2'b00;
  assign mem_addr_r_o = rd_act ? req_q.addr : 32'h0;

  assign mem_wr_en_o  = wr_act;
  assign mem_acc_w_o  = wr_act ? req_q.acc : 2'b00;
  assign mem_addr_w_o = wr_act ? req_q.addr : 32'h0;
  assign mem_data_w_o = wr_act ? req_q.wdata : 32'h0;

  assign m0_rvalid_o = rvalid_any && (req_q.id == MstM0);
  assign m0_rdata_o  = m0_rvalid_o ? rdata_any : 32'h0;
  assign m0_err_o    = err_act && (req_q.id == MstM0);

  assign m1_rvalid_o = rvalid_any && (req_q.id == MstM1);
  assign m1_rdata_o  = m1_rvalid_o ? rdata_any : 32'h0;
  assign m1_wdone_o  = wdone_any && (req_q.id == MstM1);
  assign m1_err_o    = err_act && (req_q.id == MstM1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural mem_control model and a
// response scoreboard fed at grant time.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, mem_wr_ready_i, preload;
  logic        m0_req_i, m0_sext_i, m1_req_i, m1_we_i, m1_sext_i;
  logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i, mem_data_r_i;
  logic [1:0]  m0_acc_i, m1_acc_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_wdone_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_r_en_o, mem_sext_o, mem_wr_en_o;
  logic [1:0]  mem_acc_r_o, mem_acc_w_o;
  logic [31:0] mem_addr_r_o, mem_addr_w_o, mem_data_w_o;

  mem_arbiter #(
    .ADDR_LO (32'h0000_0000),
    .ADDR_HI (32'h0000_07FF)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_acc_i       (m0_acc_i),
    .m0_sext_i      (m0_sext_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m0_err_o       (m0_err_o),
    .m1_req_i       (m1_req_i),
    .m1_we_i        (m1_we_i),
    .m1_addr_i      (m1_addr_i),
    .m1_acc_i       (m1_acc_i),
    .m1_sext_i      (m1_sext_i),
    .m1_wdata_i     (m1_wdata_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .m1_wdone_o     (m1_wdone_o),
    .m1_err_o       (m1_err_o),
    .mem_r_en_o     (mem_r_en_o),
    .mem_sext_o     (mem_sext_o),
    .mem_acc_r_o    (mem_acc_r_o),
    .mem_addr_r_o   (mem_addr_r_o),
    .mem_data_r_i   (mem_data_r_i),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_acc_w_o    (mem_acc_w_o),
    .mem_addr_w_o   (mem_addr_w_o),
    .mem_data_w_o   (mem_data_w_o),
    .mem_wr_ready_i (mem_wr_ready_i)
  );

  // ---------------- mem_control model: registered read, read-modify-write ----------------
  logic [31:0] mem [512];
  logic [31:0] rd_q;
  logic        wr_phase_q;
  assign mem_data_r_i = rd_q;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] acc, input logic sext);
    logic [31:0] s;
    s = w >> (8 * lane);
    case (acc)
      MEM_ACCESS_BYTE: return sext ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      MEM_ACCESS_HALF: return sext ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      default:         return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                        input logic [1:0] acc, input logic [31:0] d);
    logic [31:0] mask;
    case (acc)
      MEM_ACCESS_BYTE: mask = 32'h0000_00FF << (8 * lane);
      MEM_ACCESS_HALF: mask = 32'h0000_FFFF << (8 * lane);
      default:         mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((d << (8 * lane)) & mask);
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'hDEAD_BEEF;
      mem[5]   <= 32'h0000_80F0;
      mem[8]   <= 32'h1122_3344;
      mem[511] <= 32'h1234_5678;
    end
    if (rst_i) begin
      rd_q       <= 32'h0;
      wr_phase_q <= 1'b0;
    end else begin
      if (mem_r_en_o)
        rd_q <= extract(mem[mem_addr_r_o[10:2]], mem_addr_r_o[1:0], mem_acc_r_o, mem_sext_o);
      if (mem_wr_en_o) begin
        if (!wr_phase_q) begin
          if (mem_wr_ready_i) wr_phase_q <= 1'b1;
        end else begin
          mem[mem_addr_w_o[10:2]] <= merge(mem[mem_addr_w_o[10:2]], mem_addr_w_o[1:0],
                                           mem_acc_w_o, mem_data_w_o);
          wr_phase_q <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic any_out();
    return |{m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_rdata_o,
             m1_wdone_o, m1_err_o, mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o,
             mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o};
  endfunction

  typedef struct {
    logic        id;
    logic        we;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] wdata;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend0, pend1;
  logic gnt_id_q[$];
  int   gnt_cyc_q[$];

  logic        prev_r_en, prev_sext, prev_wr_en;
  logic [1:0]  prev_acc_r, prev_acc_w;
  logic [31:0] prev_addr_r, prev_addr_w, prev_data_w;

  // Scoreboard monitor: push at grant, pop and compare at every response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic r0, r1;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (m0_gnt_o || m1_gnt_o) begin
        e = m1_gnt_o ? pend1 : pend0;
        e.due = cyc + (e.err ? 1 : 2);
        exp_q.push_back(e);
        gnt_id_q.push_back(m1_gnt_o);
        gnt_cyc_q.push_back(cyc);
      end
      chk("gnt_exclusive", m0_gnt_o & m1_gnt_o, 0);
      r0 = m0_rvalid_o;
      r1 = m1_rvalid_o || m1_wdone_o;
      chk("resp_exclusive", r0 & r1, 0);
      chk("m0_rdata_idle", m0_rvalid_o ? 32'h0 : m0_rdata_o, 0);
      chk("m1_rdata_idle", m1_rvalid_o ? 32'h0 : m1_rdata_o, 0);
      chk("rd_port_idle", mem_r_en_o ? 35'h0 : {mem_sext_o, mem_acc_r_o, mem_addr_r_o}, 0);
      chk("wr_port_idle", mem_wr_en_o ? 66'h0 : {mem_acc_w_o, mem_addr_w_o, mem_data_w_o}, 0);
      if (r0 || r1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", r1, e.id);
          chk("resp_kind", m1_wdone_o, e.we);
          chk("resp_err", r1 ? m1_err_o : m0_err_o, e.err);
          chk("resp_rdata", r1 ? m1_rdata_o : m0_rdata_o, e.rdata);
          chk("resp_cycle", cyc, e.due);
          if (e.err) begin
            chk("err_no_mem", {mem_r_en_o, mem_wr_en_o, prev_r_en, prev_wr_en}, 0);
          end else if (!e.we) begin
            chk("rd_port_now", {mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o},
                {1'b1, e.sext, e.acc, e.addr});
            chk("rd_port_prev", {prev_r_en, prev_sext, prev_acc_r, prev_addr_r},
                {1'b1, e.sext, e.acc, e.addr});
            chk("rd_no_wr", mem_wr_en_o | prev_wr_en, 0);
          end else begin
            chk("wr_port_now", {mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o},
                {1'b1, e.acc, e.addr, e.wdata});
            chk("wr_port_prev", {prev_wr_en, prev_acc_w, prev_addr_w, prev_data_w},
                {1'b1, e.acc, e.addr, e.wdata});
            chk("wr_no_rd", mem_r_en_o | prev_r_en, 0);
          end
        end
      end
    end
    prev_r_en   <= mem_r_en_o;
    prev_sext   <= mem_sext_o;
    prev_acc_r  <= mem_acc_r_o;
    prev_addr_r <= mem_addr_r_o;
    prev_wr_en  <= mem_wr_en_o;
    prev_acc_w  <= mem_acc_w_o;
    prev_addr_w <= mem_addr_w_o;
    prev_data_w <= mem_data_w_o;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.id = v.mst; e.we = v.we; e.err = v.exp_err; e.rdata = v.exp_rdata;
    e.addr = v.addr; e.acc = v.acc; e.sext = v.sext; e.wdata = v.wdata; e.due = 0;
    return e;
  endfunction

  task automatic set_req(input vec_t v);
    if (v.mst) begin
      pend1 = to_exp(v);
      m1_req_i = 1'b1; m1_we_i = v.we; m1_addr_i = v.addr; m1_acc_i = v.acc;
      m1_sext_i = v.sext; m1_wdata_i = v.wdata;
    end else begin
      pend0 = to_exp(v);
      m0_req_i = 1'b1; m0_addr_i = v.addr; m0_acc_i = v.acc; m0_sext_i = v.sext;
    end
  endtask

  task automatic wait_gnt(input logic mst, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mst ? m1_gnt_o : m0_gnt_o;
    end
    chk({name, "_gnt"}, seen, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic drive_vec(input vec_t v);
    @(posedge clk); #1;
    set_req(v);
    wait_gnt(v.mst, v.name);
    @(posedge clk); #1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    wait_drain(v.name);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_i = 1'b1; mem_wr_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_outputs", any_out(), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    mem_wr_ready_i = 1'b1;
  endtask

  localparam logic [1:0] B = MEM_ACCESS_BYTE;
  localparam logic [1:0] H = MEM_ACCESS_HALF;
  localparam logic [1:0] W = MEM_ACCESS_WORD;

  vec_t vecs[15];
  vec_t v6;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h10,       W, 1'b0, 32'h0,  1'b0, 32'hDEAD_BEEF, "rd_word"};
    vecs[1]  = '{1'b1, 1'b1, 32'h13,       B, 1'b0, 32'hA5, 1'b0, 32'h0,         "wr_byte"};
    vecs[2]  = '{1'b1, 1'b0, 32'h10,       W, 1'b0, 32'h0,  1'b0, 32'hA5AD_BEEF, "rd_merged"};
    vecs[3]  = '{1'b1, 1'b0, 32'h11,       H, 1'b1, 32'h0,  1'b1, 32'h0,         "rd_half_mis"};
    vecs[4]  = '{1'b0, 1'b0, 32'h800,      W, 1'b0, 32'h0,  1'b1, 32'h0,         "rd_oor"};
    vecs[5]  = '{1'b0, 1'b0, 32'h7FC,      W, 1'b0, 32'h0,  1'b0, 32'h1234_5678, "rd_top"};
    vecs[6]  = '{1'b1, 1'b0, 32'h14,       H, 1'b1, 32'h0,  1'b0, 32'hFFFF_80F0, "rd_half_sx"};
    vecs[7]  = '{1'b0, 1'b0, 32'h15,       B, 1'b0, 32'h0,  1'b0, 32'h0000_0080, "rd_byte_zx"};
    vecs[8]  = '{1'b1, 1'b0, 32'h15,       B, 1'b1, 32'h0,  1'b0, 32'hFFFF_FF80, "rd_byte_sx"};
    vecs[9]  = '{1'b1, 1'b1, 32'h7FE,      H, 1'b0, 32'hBEEF, 1'b0, 32'h0,       "wr_half_top"};
    vecs[10] = '{1'b0, 1'b0, 32'h7FC,      W, 1'b0, 32'h0,  1'b0, 32'hBEEF_5678, "rd_top_mrg"};
    vecs[11] = '{1'b1, 1'b1, 32'h7FE,      W, 1'b0, 32'h1,  1'b1, 32'h0,         "wr_word_mis"};
    vecs[12] = '{1'b1, 1'b1, 32'h7FF,      H, 1'b0, 32'h2,  1'b1, 32'h0,         "wr_half_mis"};
    vecs[13] = '{1'b0, 1'b0, 32'hFFFF_FFFC, W, 1'b0, 32'h0, 1'b1, 32'h0,         "rd_wrap"};
    vecs[14] = '{1'b1, 1'b0, 32'h7FF,      B, 1'b0, 32'h0,  1'b0, 32'h0000_00BE, "rd_last_b"};

    rst_i = 1'b1; mem_wr_ready_i = 1'b0; preload = 1'b1;
    m0_req_i = 1'b0; m0_addr_i = '0; m0_acc_i = '0; m0_sext_i = 1'b0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_acc_i = '0; m1_sext_i = 1'b0;
    m1_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("init_rst_outputs", any_out(), 0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("idle_outputs", any_out(), 0);
    @(posedge clk); #1 mem_wr_ready_i = 1'b1;

    for (int i = 0; i < 15; i++) drive_vec(vecs[i]);

    // Contention: m1 must win first after reset, then strict alternation every 3 cycles.
    reset_pulse();
    pend0 = to_exp('{1'b0, 1'b0, 32'h10,  W, 1'b0, 32'h0, 1'b0, 32'hA5AD_BEEF, "rr0"});
    pend1 = to_exp('{1'b1, 1'b0, 32'h7FC, W, 1'b0, 32'h0, 1'b0, 32'hBEEF_5678, "rr1"});
    gnt_id_q.delete(); gnt_cyc_q.delete();
    @(posedge clk); #1;
    m0_req_i = 1'b1; m0_addr_i = 32'h10; m0_acc_i = W; m0_sext_i = 1'b0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h7FC; m1_acc_i = W; m1_sext_i = 1'b0;
    for (int i = 0; i < 40 && gnt_id_q.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    wait_drain("rr");
    chk("rr_count", gnt_id_q.size(), 4);
    for (int k = 0; k < 4 && k < gnt_id_q.size(); k++)
      chk("rr_order", gnt_id_q[k], (k % 2 == 0) ? 1 : 0);
    for (int k = 1; k < 4 && k < gnt_cyc_q.size(); k++)
      chk("rr_spacing", gnt_cyc_q[k] - gnt_cyc_q[k-1], 3);

    // Reset in WR_STORE abandons the write; next grant waits for mem_wr_ready_i.
    v6 = '{1'b1, 1'b1, 32'h20, B, 1'b0, 32'h77, 1'b0, 32'h0, "t6_wr"};
    @(posedge clk); #1;
    set_req(v6);
    wait_gnt(1'b1, "t6_wr");
    @(posedge clk); #1;
    m1_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1; mem_wr_ready_i = 1'b0;
    @(negedge clk);
    chk("t6_no_wdone", m1_wdone_o, 0);
    chk("t6_rst_outputs", any_out(), 0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("t6_post_rst_outputs", any_out(), 0);
    @(posedge clk); #1;
    set_req('{1'b0, 1'b0, 32'h20, W, 1'b0, 32'h0, 1'b0, 32'h1122_3344, "t6_rd"});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_gnt_unready", m0_gnt_o, 0);
    end
    @(posedge clk); #1 mem_wr_ready_i = 1'b1;
    @(negedge clk);
    chk("t6_gnt_when_ready", m0_gnt_o, 1);
    @(posedge clk); #1 m0_req_i = 1'b0;
    wait_drain("t6_rd");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
